// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B; grant is 1 cycle after req, z is 1 cycle after grant.
// No downstream backpressure: a requester holds req high and waits, and MAX_BURST bounds its wait while the peer is granted.
module mux_share_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] z,
  output logic             z_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  localparam logic [7:0] BEAT_MAX = 8'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_b;
  logic             w_next_last_b;
  logic [7:0]       r_beat_cnt;
  logic [7:0]       w_next_beat_cnt;
  logic             w_burst_done;
  logic [WIDTH-1:0] r_z;
  logic             r_z_valid;

  assign w_burst_done = (r_beat_cnt == BEAT_MAX);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && !req_b)      w_next_state = GNT_A;
        else if (req_b && !req_a) w_next_state = GNT_B;
        else if (req_a && req_b)  w_next_state = r_last_b ? GNT_A : GNT_B;
        else                      w_next_state = IDLE;
      end
      GNT_A: begin
        if (!req_a)                      w_next_state = req_b ? GNT_B : IDLE;
        else if (req_b && w_burst_done)  w_next_state = GNT_B;
        else                             w_next_state = GNT_A;
      end
      GNT_B: begin
        if (!req_b)                      w_next_state = req_a ? GNT_A : IDLE;
        else if (req_a && w_burst_done)  w_next_state = GNT_A;
        else                             w_next_state = GNT_B;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The counter only advances while the same grant is held; it parks at
  // BEAT_MAX so a lone requester keeps the mux until the peer shows up.
  always_comb begin
    w_next_beat_cnt = 8'd0;
    if ((w_next_state != IDLE) && (w_next_state == r_state)) begin
      w_next_beat_cnt = w_burst_done ? r_beat_cnt : (r_beat_cnt + 8'd1);
    end
  end

  always_comb begin
    w_next_last_b = r_last_b;
    if ((w_next_state == GNT_A) && (r_state != GNT_A)) w_next_last_b = 1'b0;
    if ((w_next_state == GNT_B) && (r_state != GNT_B)) w_next_last_b = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_last_b   <= w_next_last_b;
      r_beat_cnt <= w_next_beat_cnt;
    end
  end

  assign gnt_a = (r_state == GNT_A);
  assign gnt_b = (r_state == GNT_B);
  assign sel   = gnt_b;

  // z is refreshed every cycle; z_valid marks whether the sampled cycle was granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
    end else begin
      r_z       <= sel ? data_b : data_a;
      r_z_valid <= gnt_a | gnt_b;
    end
  end

  assign z       = r_z;
  assign z_valid = r_z_valid;

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter that time-shares one 2:1 multiplexer datapath (select S, output Z) between requesters A and B.
- Drives the mux select and grant lines, bounds each grant with a burst limit, and presents a registered, qualified mux output downstream.
- Sits between two data sources and a single shared consumer, replacing a hand-driven select.

Parameters:
- WIDTH, 8, data width of each source and of z.
- MAX_BURST, 4, maximum consecutive granted cycles when the other requester is waiting (legal range 1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_a  input  1  requester A wants the mux; held high while it wants it.
- req_b  input  1  requester B wants the mux; held high while it wants it.
- data_a  input  WIDTH  mux input A.
- data_b  input  WIDTH  mux input B.
- gnt_a  output  1  A owns the mux this cycle (registered).
- gnt_b  output  1  B owns the mux this cycle (registered).
- sel  output  1  mux select: 0 = A, 1 = B (registered, equals gnt_b).
- z  output  WIDTH  registered mux output.
- z_valid  output  1  z holds data from a granted cycle.

Behaviour:
- Interface: one clock (clk). Reset is rst_n, synchronous and active-low: the block resets only on a clk rising edge where rst_n = 0.
- Reset values: state = IDLE, gnt_a = 0, gnt_b = 0, sel = 0, z = 0, z_valid = 0, beat_cnt = 0, last = B, so A wins the first tie.
- FSM states: IDLE, GNT_A, GNT_B. Outputs decode from registered state: gnt_a = (GNT_A), gnt_b = (GNT_B), sel = (GNT_B).
- Transitions from IDLE:
  - Only req_a high -> GNT_A.
  - Only req_b high -> GNT_B.
  - Both high -> the requester that is not last.
  - Neither high -> stay in IDLE.
- Transitions from GNT_X (Y is the other requester):
  - req_X low and req_Y high -> GNT_Y.
  - req_X low and req_Y low -> IDLE.
  - req_X high, req_Y high, beat_cnt == MAX_BURST-1 -> GNT_Y (preemption).
  - Otherwise -> stay in GNT_X.
- A grant switch goes directly GNT_A <-> GNT_B with no idle cycle between.
- beat_cnt:
  - Cleared on entry to any GNT state and in IDLE.
  - Increments each cycle spent in a GNT state.
  - Saturates at MAX_BURST-1 while the other side is not requesting, so a lone requester holds the grant indefinitely.
- last: updated to X on entry to GNT_X.
- Grant latency: req_X rising before edge k with the mux free -> gnt_X high after edge k (1 cycle).
- Data path:
  - Each edge: z <= sel ? data_b : data_a.
  - Each edge: z_valid <= gnt_a | gnt_b.
  - z therefore carries data sampled in the granted cycle, one cycle later.
  - In idle cycles z is still updated but z_valid = 0.
- Invariants:
  - gnt_a & gnt_b == 0 at all times.
  - sel == gnt_b.
  - No grant is issued without the matching req sampled high at the preceding edge.
- Reset mid-grant: next edge forces all reset values; an outstanding req is re-arbitrated from IDLE with last = B.
- A req dropped and reasserted in the same cycle it is released is treated as a new request and loses to a waiting peer per round-robin.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with req_a=req_b=1 -> gnt_a=gnt_b=sel=z_valid=0 and z=0. Release -> gnt_a=1 after the first edge.
- Single requester: req_a=1 alone, data_a=8'h5A -> gnt_a=1 after 1 edge, z=8'h5A with z_valid=1 one edge later, grant held for 10+ cycles. Drop req_a -> IDLE next edge and z_valid=0 the edge after.
- Tie and round-robin: both req from IDLE, MAX_BURST=4 -> grant sequence A,A,A,A,B,B,B,B,A,… sel toggles with no gap, and gnt_a/gnt_b are never both 1.
- Early release: in GNT_A at beat 1, drop req_a with req_b=1 -> gnt_b=1 next edge and beat_cnt restarts at 0.
- Data routing: data_a=8'h11, data_b=8'hEE under alternating grants -> z is 8'h11 one cycle after each gnt_a cycle and 8'hEE one cycle after each gnt_b cycle.
- Reset mid-grant: assert rst_n=0 during GNT_B beat 2 -> all outputs at reset values next edge. With both reqs still high after release -> gnt_a=1 first.
